// File: rtl/cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_pkg
//  Description : Shared types and constants for the modulo counter slice.
//                - cnt_mode_t : overflow policy (CNT_WRAP or CNT_SAT)
//                - CNT_MIN_WIDTH / CNT_MAX_WIDTH : legal counter widths
//                - cnt_span() : 2**width as a 64-bit value, so that the
//                  full-range modulus is representable even at width 32
//  Revision    : 1.0  initial release
// ============================================================================
package cnt_pkg;

  typedef enum logic [0:0] {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_t;

  localparam int CNT_MIN_WIDTH = 2;
  localparam int CNT_MAX_WIDTH = 32;

  // 2**width computed in 64 bits; a 32-bit int would overflow at width 32.
  function automatic longint unsigned cnt_span(input int width);
    return 64'(1) << width;
  endfunction

endpackage : cnt_pkg
`default_nettype wire

// File: rtl/incdec_comb.sv
`default_nettype none
// ============================================================================
//  Module      : incdec_comb
//  Description : Combinational increment/decrement step for the counter.
//                Produces cnt+1 (inc only), cnt-1 (dec only) or cnt
//                (neither, or both). The extra top bit of the arithmetic is
//                exposed only as carry/borrow flags for boundary detection.
//  Ports       : cnt    in  [WIDTH-1:0] current count
//                inc    in  1           increment request
//                dec    in  1           decrement request
//                nxt    out [WIDTH-1:0] stepped value (WIDTH bits)
//                carry  out 1           increment overflowed WIDTH bits
//                borrow out 1           decrement underflowed below zero
//  Revision    : 1.0  initial release
// ============================================================================
module incdec_comb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] nxt,
  output logic             carry,
  output logic             borrow
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, cnt} + (WIDTH+1)'(1);
  assign w_diff = {1'b0, cnt} - (WIDTH+1)'(1);

  always_comb begin
    nxt    = cnt;
    carry  = 1'b0;
    borrow = 1'b0;
    if (inc && !dec) begin
      nxt   = w_sum[WIDTH-1:0];
      carry = w_sum[WIDTH];
    end else if (dec && !inc) begin
      nxt    = w_diff[WIDTH-1:0];
      borrow = w_diff[WIDTH];
    end
  end

endmodule : incdec_comb
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter
//  Description : Up/down modulo-MOD counter with clear, clamped load and a
//                selectable overflow policy (wrap or saturate). tc is a
//                registered one-cycle pulse flagging a wrap or a blocked
//                saturating request on the previous edge.
//  Ports       : clk     in  1           clock, rising edge
//                rst_n   in  1           asynchronous active-low reset
//                clr     in  1           synchronous clear (highest priority)
//                ld      in  1           synchronous load of ld_val
//                ld_val  in  [WIDTH-1:0] load value (clamped to MOD-1)
//                inc     in  1           increment request
//                dec     in  1           decrement request
//                cnt     out [WIDTH-1:0] registered count
//                tc      out 1           registered terminal-count pulse
//                at_max  out 1           cnt == MOD-1 (from register only)
//                at_zero out 1           cnt == 0     (from register only)
//  Revision    : 1.0  initial release
// ============================================================================
module mod_counter
  import cnt_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter longint unsigned MOD   = cnt_span(WIDTH),
  parameter cnt_mode_t       MODE  = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if (WIDTH < CNT_MIN_WIDTH || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
    $error("mod_counter: WIDTH=%0d outside %0d..%0d", WIDTH, CNT_MIN_WIDTH, CNT_MAX_WIDTH);
  end

  if (MOD < 2 || MOD > cnt_span(WIDTH)) begin : g_bad_mod
    $error("mod_counter: MOD=%0d outside 2..2**WIDTH", MOD);
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam bit               SAT     = (MODE == CNT_SAT);

  // --------------------------------------------------------------------------
  // Step arithmetic
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_nxt;
  logic             w_carry;
  logic             w_borrow;

  incdec_comb #(
    .WIDTH (WIDTH)
  ) u_incdec (
    .cnt    (cnt),
    .inc    (inc),
    .dec    (dec),
    .nxt    (w_nxt),
    .carry  (w_carry),
    .borrow (w_borrow)
  );

  logic w_up_req;
  logic w_dn_req;
  logic w_up_hit;
  logic w_dn_hit;

  assign w_up_req = inc & ~dec;
  assign w_dn_req = dec & ~inc;

  // For a full-range modulus the top boundary coincides with the carry out
  // of the adder; for smaller moduli it is the MOD-1 compare.
  assign w_up_hit = w_up_req & (at_max | w_carry);
  // cnt is never >= MOD, so a borrow happens exactly when stepping down from 0.
  assign w_dn_hit = w_dn_req & w_borrow;

  // Load values at or above the modulus are clamped to the top count. The
  // compare is done in 64 bits so MOD = 2**32 needs no special case.
  logic [WIDTH-1:0] w_ld_clamped;

  always_comb begin
    w_ld_clamped = ld_val;
    if (64'(ld_val) >= MOD) begin
      w_ld_clamped = MAX_VAL;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state selection: clr > ld > single step > hold
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_cnt_d;
  logic             w_tc_d;

  always_comb begin
    w_cnt_d = cnt;
    w_tc_d  = 1'b0;
    if (clr) begin
      w_cnt_d = '0;
    end else if (ld) begin
      w_cnt_d = w_ld_clamped;
    end else if (w_up_hit) begin
      w_tc_d  = 1'b1;
      w_cnt_d = SAT ? MAX_VAL : '0;
    end else if (w_dn_hit) begin
      w_tc_d  = 1'b1;
      w_cnt_d = SAT ? '0 : MAX_VAL;
    end else begin
      // Covers in-range steps as well as hold (nxt == cnt when inc == dec).
      w_cnt_d = w_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else begin
      cnt <= w_cnt_d;
      tc  <= w_tc_d;
    end
  end

  assign at_max  = (cnt == MAX_VAL);
  assign at_zero = (cnt == '0);

endmodule : mod_counter
`default_nettype wire
